// File: rtl/bexkat2_intunit_pkg.sv
// Shared definitions for the bexkat2 integer unit: function codes, unit states,
// fixed latency overhead and operation-class helpers.
// Imported by bexkat2_intunit; holds no logic of its own.
package bexkat1Def;

    // Integer unit function codes (codes 12-15 are unused and act as a zero-result unary op).
    typedef enum logic [3:0] {
        INT_MUL   = 4'h0,
        INT_DIV   = 4'h1,
        INT_MOD   = 4'h2,
        INT_MULU  = 4'h3,
        INT_DIVU  = 4'h4,
        INT_MODU  = 4'h5,
        INT_MULX  = 4'h6,
        INT_MULUX = 4'h7,
        INT_EXT   = 4'h8,
        INT_EXTB  = 4'h9,
        INT_COM   = 4'ha,
        INT_NEG   = 4'hb
    } intfunc_t;

    typedef enum logic [2:0] {
        IS_IDLE  = 3'd0,
        IS_UNARY = 3'd1,
        IS_ZERO  = 3'd2,
        IS_CALC  = 3'd3,
        IS_FIX   = 3'd4,
        IS_DONE  = 3'd5
    } intstate_t;

    // Cycles added to WIDTH for the iterative (multiply/divide) operations.
    localparam int INT_LATENCY_ITER = 2;

    function automatic logic int_is_div(input logic [3:0] f);
        return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
    endfunction

    function automatic logic int_is_mul(input logic [3:0] f);
        return (f == INT_MUL) || (f == INT_MULU) || (f == INT_MULX) || (f == INT_MULUX);
    endfunction

    function automatic logic int_is_signed(input logic [3:0] f);
        return (f == INT_MUL) || (f == INT_DIV) || (f == INT_MOD) || (f == INT_MULX);
    endfunction

endpackage

// File: rtl/bexkat2_intunit.sv
// Multi-cycle integer unit: mul/div/mod (signed+unsigned, low/high product) and unary ext/com/neg.
// Latency: unary and divide-by-zero done 2 cycles after accept, multiply/divide WIDTH+2 cycles.
// Backpressure: start_i is only sampled in IDLE; abort_i cancels any in-flight op without done_o.
// Ports: clk_i/rst_ni, start_i/func_i/a_i/b_i launch, abort_i cancel,
//        busy_o/done_o status, result_o (held between done pulses), divzero_o (valid with done_o).
module bexkat2_intunit
    import bexkat1Def::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             divzero_o
);

    localparam int CW = $clog2(WIDTH);

    // Magnitude of a value, treating it as two's complement only when sgn is set.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    intstate_t          state_q, state_d;
    logic [3:0]         func_q;
    logic [WIDTH-1:0]   a_q;        // raw operand A for unary / divide-by-zero results
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;      // shared multiply/divide accumulator
    logic [CW-1:0]      count_q;
    logic               mode_q;     // 1 = divide, 0 = multiply
    logic               neg_q;      // negate product / quotient at fix-up
    logic               rneg_q;     // negate remainder at fix-up (sign of dividend)
    logic [WIDTH-1:0]   result_q, result_d;
    logic               divzero_q, divzero_d;
    logic               res_we;

    logic               accept;
    assign accept = (state_q == IS_IDLE) && start_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IS_IDLE: begin
                if (start_i) begin
                    if (int_is_div(func_i) && (b_i == '0)) begin
                        state_d = IS_ZERO;
                    end else if (int_is_div(func_i) || int_is_mul(func_i)) begin
                        state_d = IS_CALC;
                    end else begin
                        state_d = IS_UNARY;
                    end
                end
            end
            IS_UNARY, IS_ZERO, IS_FIX: state_d = abort_i ? IS_IDLE : IS_DONE;
            IS_CALC: begin
                if (abort_i) begin
                    state_d = IS_IDLE;
                end else if (count_q == '0) begin
                    state_d = IS_FIX;
                end
            end
            // Completion already happened; abort here cannot suppress done_o.
            IS_DONE: state_d = IS_IDLE;
            default: state_d = IS_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration step: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (mode_q) begin
            // diff[WIDTH+1] set means the trial subtraction went negative: restore.
            acc_step = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Output / result logic
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        busy_o    = (state_q != IS_IDLE);
        done_o    = (state_q == IS_DONE);
        res_we    = 1'b0;
        result_d  = result_q;
        divzero_d = 1'b0;
        prod      = neg_q ? -acc_q : acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
        case (state_q)
            IS_UNARY: begin
                res_we = !abort_i;
                case (func_q)
                    INT_EXT:  result_d = WIDTH'($signed(a_q[15:0]));
                    INT_EXTB: result_d = WIDTH'($signed(a_q[7:0]));
                    INT_COM:  result_d = ~a_q;
                    INT_NEG:  result_d = -a_q;
                    default:  result_d = '0;
                endcase
            end
            IS_ZERO: begin
                res_we    = !abort_i;
                divzero_d = 1'b1;
                result_d  = ((func_q == INT_DIV) || (func_q == INT_DIVU)) ? '1 : a_q;
            end
            IS_FIX: begin
                res_we = !abort_i;
                case (func_q)
                    INT_MUL, INT_MULU:   result_d = prod[WIDTH-1:0];
                    INT_MULX, INT_MULUX: result_d = prod[2*WIDTH-1:WIDTH];
                    INT_DIV, INT_DIVU:   result_d = neg_q ? -quo : quo;
                    INT_MOD, INT_MODU:   result_d = rneg_q ? -rem : rem;
                    default:             result_d = '0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q  <= '0;
            divzero_q <= 1'b0;
        end else if (res_we) begin
            result_q  <= result_d;
            divzero_q <= divzero_d;
        end
    end

    assign result_o  = result_q;
    assign divzero_o = divzero_q;

    // ------------------------------------------------------------------
    // Operand capture and iteration datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            func_q  <= '0;
            a_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (accept) begin
            func_q  <= func_i;
            a_q     <= a_i;
            count_q <= CW'(WIDTH - 1);
            mode_q  <= int_is_div(func_i);
            neg_q   <= int_is_signed(func_i) && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q  <= int_is_signed(func_i) && a_i[WIDTH-1];
            if (int_is_div(func_i)) begin
                acc_q  <= {{WIDTH{1'b0}}, mag(a_i, int_is_signed(func_i))};
                opnd_q <= mag(b_i, int_is_signed(func_i));
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, mag(b_i, int_is_signed(func_i))};
                opnd_q <= mag(a_i, int_is_signed(func_i));
            end
        end else if (state_q == IS_CALC) begin
            acc_q   <= acc_step;
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_bexkat2_intunit.sv
module tb_bexkat2_intunit;
    import bexkat1Def::*;

    typedef struct {
        string       name;
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st32 = 0, ab32 = 0, busy32, done32, dz32;
    logic [3:0]  fn32 = 0;
    logic [31:0] a32 = 0, b32 = 0, res32;
    logic        st16 = 0, ab16 = 0, busy16, done16, dz16;
    logic [3:0]  fn16 = 0;
    logic [15:0] a16 = 0, b16 = 0, res16;

    bexkat2_intunit #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st32), .func_i(fn32), .a_i(a32), .b_i(b32),
        .abort_i(ab32), .busy_o(busy32), .done_o(done32), .result_o(res32), .divzero_o(dz32));

    bexkat2_intunit #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st16), .func_i(fn16), .a_i(a16), .b_i(b16),
        .abort_i(ab16), .busy_o(busy16), .done_o(done16), .result_o(res16), .divzero_o(dz16));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic set_in(input int w, input logic s, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic ab);
        if (w == 16) begin
            st16 = s; fn16 = f; a16 = a[15:0]; b16 = b[15:0]; ab16 = ab;
        end else begin
            st32 = s; fn32 = f; a32 = a; b32 = b; ab32 = ab;
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done32;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 16) ? busy16 : busy32;
    endfunction
    function automatic logic [31:0] get_res(input int w);
        return (w == 16) ? {16'h0, res16} : res32;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 16) ? dz16 : dz32;
    endfunction

    function automatic vec_t mk(input string n, input logic [3:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] r, input logic dz,
                                input int lat);
        vec_t v;
        v.name = n; v.func = f; v.a = a; v.b = b; v.res = r; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    // Launch one op; cyc counts falling edges after the accepting rising edge.
    // With poke set, a second start is pulsed while the unit is busy.
    task automatic run_vec(input int w, input vec_t v, input bit poke);
        int cyc;
        @(negedge clk);
        set_in(w, 1'b1, v.func, v.a, v.b, 1'b0);
        @(negedge clk);
        set_in(w, 1'b0, 4'hf, $urandom, $urandom, 1'b0);
        cyc = 1;
        while (!get_done(w) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) set_in(w, 1'b1, INT_MUL, 32'h3, 32'h5, 1'b0);
            if (poke && cyc == 4) set_in(w, 1'b0, INT_MUL, 32'h0, 32'h0, 1'b0);
        end
        chk($sformatf("w%0d %s latency", w, v.name), cyc, v.lat);
        chk($sformatf("w%0d %s result", w, v.name), get_res(w), v.res);
        chk($sformatf("w%0d %s divzero", w, v.name), {31'h0, get_dz(w)}, {31'h0, v.dz});
    endtask

    // Start an op on the 32-bit unit and abort it at falling edge k; the unit must
    // be idle on the next cycle, never pulse done_o, and keep the previous result.
    task automatic abort_at(input string name, input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, input int k, input logic [31:0] prev);
        int cyc;
        int dones;
        @(negedge clk);
        set_in(32, 1'b1, f, a, b, 1'b0);
        @(negedge clk);
        set_in(32, 1'b0, f, a, b, 1'b0);
        cyc = 1;
        dones = 0;
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
        ab32 = 1'b1;
        @(negedge clk);
        ab32 = 1'b0;
        chk({name, " busy after abort"}, {31'h0, busy32}, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (done32) dones++;
            @(negedge clk);
        end
        chk({name, " done pulses"}, dones, 0);
        chk({name, " result held"}, res32, prev);
    endtask

    vec_t t32[$];
    vec_t t16[$];

    initial begin
        t32.push_back(mk("MUL",     INT_MUL,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 0, 34));
        t32.push_back(mk("MULX",    INT_MULX,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 34));
        t32.push_back(mk("MULUX",   INT_MULUX, 32'hFFFFFFFF, 32'h2,        32'h00000001, 0, 34));
        t32.push_back(mk("MULU",    INT_MULU,  32'h00010001, 32'h00010000, 32'h00010000, 0, 34));
        t32.push_back(mk("MULneg",  INT_MUL,   32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 0, 34));
        t32.push_back(mk("DIV",     INT_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 34));
        t32.push_back(mk("MOD",     INT_MOD,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 34));
        t32.push_back(mk("DIVnb",   INT_DIV,   32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34));
        t32.push_back(mk("MODnb",   INT_MOD,   32'h7,        32'hFFFFFFFE, 32'h00000001, 0, 34));
        t32.push_back(mk("MODU",    INT_MODU,  32'h7,        32'h2,        32'h00000001, 0, 34));
        t32.push_back(mk("DIVU",    INT_DIVU,  32'd100,      32'd7,        32'd14,       0, 34));
        t32.push_back(mk("DIVU0",   INT_DIVU,  32'h5,        32'h0,        32'hFFFFFFFF, 1, 2));
        t32.push_back(mk("MOD0",    INT_MOD,   32'h5,        32'h0,        32'h00000005, 1, 2));
        t32.push_back(mk("DIVovf",  INT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 34));
        t32.push_back(mk("MODovf",  INT_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 34));
        t32.push_back(mk("EXTB",    INT_EXTB,  32'h00000080, 32'h0,        32'hFFFFFF80, 0, 2));
        t32.push_back(mk("EXT",     INT_EXT,   32'h00017FFF, 32'h0,        32'h00007FFF, 0, 2));
        t32.push_back(mk("NEG",     INT_NEG,   32'h80000000, 32'h0,        32'h80000000, 0, 2));
        t32.push_back(mk("COM",     INT_COM,   32'h0F0F0000, 32'h0,        32'hF0F0FFFF, 0, 2));
        t32.push_back(mk("code13",  4'd13,     32'h12345678, 32'h9,        32'h00000000, 0, 2));

        t16.push_back(mk("MUL",     INT_MUL,   32'hFFFF, 32'h2,    32'hFFFE, 0, 18));
        t16.push_back(mk("MULX",    INT_MULX,  32'hFFFF, 32'h2,    32'hFFFF, 0, 18));
        t16.push_back(mk("MULUX",   INT_MULUX, 32'hFFFF, 32'h2,    32'h0001, 0, 18));
        t16.push_back(mk("DIV",     INT_DIV,   32'hFFF9, 32'h2,    32'hFFFD, 0, 18));
        t16.push_back(mk("MOD",     INT_MOD,   32'hFFF9, 32'h2,    32'hFFFF, 0, 18));
        t16.push_back(mk("MODU",    INT_MODU,  32'h7,    32'h2,    32'h0001, 0, 18));
        t16.push_back(mk("DIVU0",   INT_DIVU,  32'h5,    32'h0,    32'hFFFF, 1, 2));
        t16.push_back(mk("DIVovf",  INT_DIV,   32'h8000, 32'hFFFF, 32'h8000, 0, 18));
        t16.push_back(mk("EXTB",    INT_EXTB,  32'h0080, 32'h0,    32'hFF80, 0, 2));
        t16.push_back(mk("NEG",     INT_NEG,   32'h8000, 32'h0,    32'h8000, 0, 2));

        // Reset state
        #12;
        chk("reset busy",    {31'h0, busy32}, 32'h0);
        chk("reset done",    {31'h0, done32}, 32'h0);
        chk("reset result",  res32, 32'h0);
        chk("reset divzero", {31'h0, dz32}, 32'h0);
        chk("reset16 result", {16'h0, res16}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (t32[i]) run_vec(32, t32[i], 1'b0);
        foreach (t16[i]) run_vec(16, t16[i], 1'b0);

        // Abort mid-divide; previous result (code13 -> 0) replaced first by a known value.
        run_vec(32, mk("pre", INT_COM, 32'h0000FFFF, 32'h0, 32'hFFFF0000, 0, 2), 1'b0);
        abort_at("abort mid DIV", INT_DIV, 32'd1000, 32'd3, 10, 32'hFFFF0000);
        run_vec(32, mk("MUL3x4", INT_MUL, 32'h3, 32'h4, 32'd12, 0, 34), 1'b0);

        // Abort coinciding with the last CALC step wins over the move to FIX.
        abort_at("abort last CALC", INT_MULU, 32'h7, 32'h9, 32, 32'd12);

        // start_i while busy is ignored.
        run_vec(32, mk("DIVU poked", INT_DIVU, 32'd100, 32'd7, 32'd14, 0, 34), 1'b1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        set_in(32, 1'b1, INT_MUL, 32'h5, 32'h6, 1'b0);
        @(negedge clk);
        set_in(32, 1'b0, INT_MUL, 32'h0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre-reset busy", {31'h0, busy32}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy",   {31'h0, busy32}, 32'h0);
        chk("async reset done",   {31'h0, done32}, 32'h0);
        chk("async reset result", res32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(32, mk("MUL after reset", INT_MUL, 32'h5, 32'h6, 32'd30, 0, 34), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
